// File: rtl/fprint_compare_ctrl_pkg.sv
// Shared widths, FSM state encoding and the task-id priority encoder for the
// dual-core fingerprint compare sequencer.
package fprint_compare_ctrl_pkg;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned CRC_W     = 32;
  localparam int unsigned KEY_W     = 4;
  localparam int unsigned NUM_TASKS = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    COMPARE  = 3'd2,
    ADVANCE  = 3'd3,
    MISMATCH = 3'd4,
    VERIFY   = 3'd5
  } state_e;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [KEY_W-1:0] lowest_set(input logic [NUM_TASKS-1:0] vec);
    logic [KEY_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_TASKS; i++) begin
      if (vec[i] && !found) begin
        idx   = KEY_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fprint_compare_ctrl_ptr_pair.sv
// Head/tail pointer pair for one core's fingerprint RAM. Pointers carry one
// extra wrap bit so occupancy distinguishes full from empty.
module fprint_ptr_pair
  import fprint_compare_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  input  logic              adv_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] head_o,
  output logic [ADDR_W-1:0] tail_o,
  output logic [ADDR_W:0]   occ_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] head_q, head_d;
  logic [ADDR_W:0] tail_q, tail_d;

  // Next pointers: flush snaps tail to the registered head, so an increment
  // on the same edge survives as a single queued entry.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (inc_i) head_d = head_q + ONE;
    if (flush_i)    tail_d = head_q;
    else if (adv_i) tail_d = tail_q + ONE;
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign head_o  = head_q[ADDR_W-1:0];
  assign tail_o  = tail_q[ADDR_W-1:0];
  assign occ_o   = head_q - tail_q;
  // occ never exceeds 2^ADDR_W, so the top bit alone marks full.
  assign full_o  = occ_o[ADDR_W];
  assign empty_o = (occ_o == '0);

endmodule

// File: rtl/fprint_compare_ctrl.sv
// Fingerprint compare sequencer: grants head increments, walks both RAMs in
// lockstep, flags mismatches and hands drained tasks to the register block.
module fprint_compare_ctrl
  import fprint_compare_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc_hp_req,
  input  logic                 inc_hp_core,
  output logic                 inc_hp_ack,
  input  logic                 hp_sel,
  output logic [ADDR_W-1:0]    head_pointer,
  output logic [ADDR_W-1:0]    tail_pointer0,
  output logic [ADDR_W-1:0]    tail_pointer1,
  input  logic [CRC_W-1:0]     fprint0,
  input  logic [CRC_W-1:0]     fprint1,
  input  logic [NUM_TASKS-1:0] checkin,
  output logic                 task_verified,
  output logic [KEY_W-1:0]     verified_task,
  input  logic                 fprint_reg_ack,
  output logic                 mismatch_irq,
  output logic [ADDR_W-1:0]    mismatch_addr,
  input  logic                 irq_clear,
  output logic [15:0]          match_count
);

  state_e              state_q, state_d;
  logic                ack_q, ack_d;
  logic                irq_q, irq_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [KEY_W-1:0]    vtask_q, vtask_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                inc0, inc1, adv, flush;
  logic [ADDR_W-1:0]   head0, head1, tail0, tail1;
  logic [ADDR_W:0]     occ0, occ1;
  logic                full0, full1, empty0, empty1;

  fprint_ptr_pair u_ptr0 (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (inc0),
    .adv_i   (adv),
    .flush_i (flush),
    .head_o  (head0),
    .tail_o  (tail0),
    .occ_o   (occ0),
    .full_o  (full0),
    .empty_o (empty0)
  );

  fprint_ptr_pair u_ptr1 (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (inc1),
    .adv_i   (adv),
    .flush_i (flush),
    .head_o  (head1),
    .tail_o  (tail1),
    .occ_o   (occ1),
    .full_o  (full1),
    .empty_o (empty1)
  );

  // Increment grant: skip the cycle after an ack so the requester can drop.
  always_comb begin
    ack_d = inc_hp_req && !(inc_hp_core ? full1 : full0) && !ack_q;
    inc0  = ack_d && !inc_hp_core;
    inc1  = ack_d && inc_hp_core;
  end

  // Compare/verify sequencer next-state and datapath controls.
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    maddr_d = maddr_q;
    vtask_d = vtask_q;
    cnt_d   = cnt_q;
    adv     = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (irq_q) begin
          state_d = IDLE;
        end else if (occ0 != '0 && occ1 != '0) begin
          state_d = FETCH;
        end else if (empty0 && empty1 && checkin != '0) begin
          state_d = VERIFY;
          vtask_d = lowest_set(checkin);
        end
      end
      FETCH: state_d = COMPARE;
      COMPARE: begin
        if (fprint0 == fprint1) begin
          state_d = ADVANCE;
        end else begin
          irq_d   = 1'b1;
          maddr_d = tail0;
          state_d = MISMATCH;
        end
      end
      ADVANCE: begin
        adv     = 1'b1;
        cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        state_d = IDLE;
      end
      MISMATCH: begin
        if (irq_clear) begin
          flush   = 1'b1;
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      VERIFY: begin
        if (fprint_reg_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any handshake at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      irq_q   <= 1'b0;
      maddr_q <= '0;
      vtask_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      irq_q   <= irq_d;
      maddr_q <= maddr_d;
      vtask_q <= vtask_d;
      cnt_q   <= cnt_d;
    end
  end

  assign inc_hp_ack    = ack_q;
  assign head_pointer  = hp_sel ? head1 : head0;
  assign tail_pointer0 = tail0;
  assign tail_pointer1 = tail1;
  assign task_verified = (state_q == VERIFY);
  assign verified_task = vtask_q;
  assign mismatch_irq  = irq_q;
  assign mismatch_addr = maddr_q;
  assign match_count   = cnt_q;

endmodule

// File: tb/tb_fprint_compare_ctrl.sv
// Directed bench for fprint_compare_ctrl with a registered-read RAM model
// per core and hand-computed expectations.
`timescale 1ns/1ps
module tb_fprint_compare_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inc_hp_req = 1'b0;
  logic        inc_hp_core = 1'b0;
  logic        inc_hp_ack;
  logic        hp_sel = 1'b0;
  logic [4:0]  head_pointer, tail_pointer0, tail_pointer1;
  logic [31:0] fprint0 = '0, fprint1 = '0;
  logic [15:0] checkin = '0;
  logic        task_verified;
  logic [3:0]  verified_task;
  logic        fprint_reg_ack = 1'b0;
  logic        mismatch_irq;
  logic [4:0]  mismatch_addr;
  logic        irq_clear = 1'b0;
  logic [15:0] match_count;

  logic [31:0] ram0 [32];
  logic [31:0] ram1 [32];
  int unsigned hm0, hm1;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  fprint_compare_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .inc_hp_req     (inc_hp_req),
    .inc_hp_core    (inc_hp_core),
    .inc_hp_ack     (inc_hp_ack),
    .hp_sel         (hp_sel),
    .head_pointer   (head_pointer),
    .tail_pointer0  (tail_pointer0),
    .tail_pointer1  (tail_pointer1),
    .fprint0        (fprint0),
    .fprint1        (fprint1),
    .checkin        (checkin),
    .task_verified  (task_verified),
    .verified_task  (verified_task),
    .fprint_reg_ack (fprint_reg_ack),
    .mismatch_irq   (mismatch_irq),
    .mismatch_addr  (mismatch_addr),
    .irq_clear      (irq_clear),
    .match_count    (match_count)
  );

  // Registered-read fingerprint RAMs addressed by the tails.
  always @(posedge clk) begin
    fprint0 <= ram0[tail_pointer0];
    fprint1 <= ram1[tail_pointer1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic core, input logic [31:0] data, input string tag);
    bit acked;
    acked = 1'b0;
    if (core) ram1[hm1[4:0]] = data;
    else      ram0[hm0[4:0]] = data;
    inc_hp_core = core;
    inc_hp_req  = 1'b1;
    for (int i = 0; i < 8 && !acked; i++) begin
      step();
      if (inc_hp_ack) acked = 1'b1;
    end
    inc_hp_req = 1'b0;
    if (acked) begin
      if (core) hm1++;
      else      hm0++;
    end
    check(tag, 32'(acked), 32'd1);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    inc_hp_req     = 1'b0;
    irq_clear      = 1'b0;
    fprint_reg_ack = 1'b0;
    checkin        = '0;
    hp_sel         = 1'b0;
    hm0            = 0;
    hm1            = 0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_matches(input logic [15:0] n, input string tag);
    int k;
    k = 0;
    while (match_count !== n && k < 400) begin
      step();
      k++;
    end
    check(tag, 32'(match_count), 32'(n));
  endtask

  task automatic wait_verify(input string tag);
    int k;
    k = 0;
    while (task_verified !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check(tag, 32'(task_verified), 32'd1);
  endtask

  initial begin
    bit seen;
    int k;
    for (int i = 0; i < 32; i++) begin
      ram0[i] = '0;
      ram1[i] = '0;
    end

    // Reset state
    do_reset();
    check("rst_ack",   32'(inc_hp_ack),    0);
    check("rst_head",  32'(head_pointer),  0);
    check("rst_tail0", 32'(tail_pointer0), 0);
    check("rst_tail1", 32'(tail_pointer1), 0);
    check("rst_tv",    32'(task_verified), 0);
    check("rst_vt",    32'(verified_task), 0);
    check("rst_irq",   32'(mismatch_irq),  0);
    check("rst_maddr", 32'(mismatch_addr), 0);
    check("rst_cnt",   32'(match_count),   0);

    // Fill and compare
    push(1'b0, 32'hDEADBEEF, "f_push");
    push(1'b1, 32'hDEADBEEF, "f_push");
    push(1'b0, 32'h12345678, "f_push");
    push(1'b1, 32'h12345678, "f_push");
    push(1'b0, 32'h00000000, "f_push");
    push(1'b1, 32'h00000000, "f_push");
    wait_matches(16'd3, "f_cnt");
    check("f_tail0", 32'(tail_pointer0), 3);
    check("f_tail1", 32'(tail_pointer1), 3);
    check("f_irq",   32'(mismatch_irq),  0);
    hp_sel = 1'b1;
    #1;
    check("f_head1", 32'(head_pointer), 3);
    hp_sel = 1'b0;
    #1;
    check("f_head0", 32'(head_pointer), 3);

    // Mismatch with two entries queued behind
    do_reset();
    push(1'b0, 32'hAAAA5555, "m_push");
    push(1'b1, 32'hAAAA5554, "m_push");
    push(1'b0, 32'h00000001, "m_push");
    push(1'b1, 32'h00000001, "m_push");
    push(1'b0, 32'h00000002, "m_push");
    push(1'b1, 32'h00000002, "m_push");
    k = 0;
    while (mismatch_irq !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    step();
    check("m_irq",   32'(mismatch_irq),  1);
    check("m_addr",  32'(mismatch_addr), 0);
    check("m_tail0", 32'(tail_pointer0), 0);
    check("m_cnt",   32'(match_count),   0);
    // irq_clear and a core0 increment land on the same edge
    ram0[3]     = 32'h00000055;
    inc_hp_core = 1'b0;
    inc_hp_req  = 1'b1;
    irq_clear   = 1'b1;
    step();
    irq_clear  = 1'b0;
    inc_hp_req = 1'b0;
    hm0        = 4;
    check("mc_ack",   32'(inc_hp_ack),    1);
    check("mc_irq",   32'(mismatch_irq),  0);
    check("mc_tail0", 32'(tail_pointer0), 3);
    check("mc_tail1", 32'(tail_pointer1), 3);
    check("mc_head0", 32'(head_pointer),  4);
    push(1'b1, 32'h00000055, "mc_push");
    wait_matches(16'd1, "mc_cnt");
    check("mc_tail0b", 32'(tail_pointer0), 4);
    check("mc_tail1b", 32'(tail_pointer1), 4);

    // Backpressure on a full core0
    do_reset();
    for (int i = 0; i < 32; i++) push(1'b0, 32'hCAFEF00D, "bp_push");
    irq_clear = 1'b1;
    step();
    irq_clear = 1'b0;
    check("bp_clr_ignored", 32'(tail_pointer0), 0);
    check("bp_head_wrap",   32'(head_pointer),  0);
    ram0[hm0[4:0]] = 32'hCAFEF00D;
    inc_hp_core = 1'b0;
    inc_hp_req  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (inc_hp_ack) seen = 1'b1;
    end
    inc_hp_req = 1'b0;
    check("bp_held", 32'(seen), 0);
    push(1'b1, 32'hCAFEF00D, "bp_core1");
    inc_hp_core = 1'b0;
    inc_hp_req  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (inc_hp_ack) seen = 1'b1;
    end
    inc_hp_req = 1'b0;
    check("bp_acked",    32'(seen),          1);
    check("bp_tail0",    32'(tail_pointer0), 1);
    check("bp_cnt",      32'(match_count),   1);

    // Wrap: 40 matched pairs
    do_reset();
    for (int i = 0; i < 40; i++) begin
      push(1'b0, 32'h5A000000 ^ 32'(i), "w_push");
      push(1'b1, 32'h5A000000 ^ 32'(i), "w_push");
      step();
    end
    wait_matches(16'd40, "w_cnt");
    check("w_tail0", 32'(tail_pointer0), 8);
    check("w_tail1", 32'(tail_pointer1), 8);
    check("w_head0", 32'(head_pointer),  8);
    check("w_irq",   32'(mismatch_irq),  0);

    // Verify handshakes
    do_reset();
    checkin = 16'h0014;
    wait_verify("v1_tv");
    check("v1_task", 32'(verified_task), 2);
    fprint_reg_ack = 1'b1;
    checkin        = 16'h0010;
    step();
    fprint_reg_ack = 1'b0;
    check("v1_drop", 32'(task_verified), 0);
    wait_verify("v2_tv");
    check("v2_task", 32'(verified_task), 4);

    // Asynchronous reset while task_verified is high
    reset = 1'b1;
    #1;
    check("r_tv",   32'(task_verified), 0);
    check("r_vt",   32'(verified_task), 0);
    check("r_irq",  32'(mismatch_irq),  0);
    check("r_ack",  32'(inc_hp_ack),    0);
    check("r_cnt",  32'(match_count),   0);
    checkin = '0;
    step();
    reset = 1'b0;
    step();
    step();
    check("r_idle", 32'(task_verified), 0);
    checkin = 16'h0008;
    wait_verify("r_tv_again");
    check("r_task", 32'(verified_task), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fprint_compare_ctrl.md
Name: fprint_compare_ctrl

Overview:
- Sequencer for the dual-core fingerprint store.
- Owns the per-core head and tail pointers of the fingerprint RAMs and grants head-pointer increments from the fingerprint register block.
- Walks both RAMs in lockstep, compares fprint0 against fprint1, and raises a mismatch interrupt on any difference.
- Issues task-verified handshakes when a checked-in task has fully drained from both cores.

Parameters:
- ADDR_W, 5: fingerprint RAM address width; depth is 2^ADDR_W.
- CRC_W, 32: fingerprint width.
- KEY_W, 4: task id width.
- NUM_TASKS, 16: checkin vector width; equals 2^KEY_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- inc_hp_req  in  1  head-pointer increment request; level, held until acked.
- inc_hp_core  in  1  logical core of the request.
- inc_hp_ack  out  1  one-cycle grant.
- hp_sel  in  1  selects which core's head pointer appears on head_pointer.
- head_pointer  out  ADDR_W  combinational: head1 if hp_sel, else head0.
- tail_pointer0  out  ADDR_W  read address, core-0 RAM.
- tail_pointer1  out  ADDR_W  read address, core-1 RAM.
- fprint0  in  CRC_W  core-0 RAM data; registered read, valid 1 cycle after the tail changes.
- fprint1  in  CRC_W  core-1 RAM data; same timing.
- checkin  in  NUM_TASKS  tasks checked in by both cores.
- task_verified  out  1  verify request to the register block.
- verified_task  out  KEY_W  task being verified.
- fprint_reg_ack  in  1  register block has cleared that task.
- mismatch_irq  out  1  level interrupt.
- mismatch_addr  out  ADDR_W  tail0 value at the mismatch.
- irq_clear  in  1  monitor acknowledge; triggers flush.
- match_count  out  16  count of successful compares; saturating.

Behaviour:
- Reset: all pointers, counters and outputs are 0; FSM enters IDLE.
- Occupancy per core: occ = head - tail, ADDR_W+1 bits, with one extra wrap bit on each pointer. Full when occ == 2^ADDR_W. Pointer wrap is modulo 2^ADDR_W on the address bits.
- Increment path, independent of the FSM:
  - When inc_hp_req is high and the target core is not full, pulse inc_hp_ack for 1 cycle and increment that head on the same edge.
  - A request is never acked in the cycle immediately after its ack. This lets the requester drop the request.
  - If the target core is full, hold ack low (backpressure) until the tail advances.
  - A simultaneous head increment and tail advance on the same core leaves occ unchanged.
- FSM states:
  - IDLE, with priority order:
    - mismatch_irq set: remain in IDLE.
    - else occ0 > 0 and occ1 > 0: go to FETCH.
    - else occ0 == 0, occ1 == 0 and checkin != 0: go to VERIFY.
  - FETCH: 1-cycle RAM latency wait, then go to COMPARE.
  - COMPARE:
    - fprint0 == fprint1: go to ADVANCE.
    - otherwise: set mismatch_irq, latch mismatch_addr = tail0, go to MISMATCH.
  - ADVANCE: tail0++, tail1++, match_count++ (saturates at 0xFFFF), go to IDLE. Compare throughput is 1 entry per 4 cycles.
  - MISMATCH: hold until irq_clear. On irq_clear, set tail0 := head0 and tail1 := head1 (registered values), clear mismatch_irq, go to IDLE. Any head increment in that same cycle survives and leaves occ = 1.
  - VERIFY:
    - task_verified = 1; verified_task = index of the lowest set bit of checkin, latched on entry.
    - On fprint_reg_ack, deassert and go to IDLE. The checkin bit is already cleared when IDLE next samples it.
- irq_clear outside MISMATCH is ignored.
- Reset mid-operation aborts any handshake immediately: ack, task_verified and irq all return to 0.

Decomposition:
- Shared package/defines: ADDR_W, CRC_W, KEY_W, NUM_TASKS; FSM state encodings IDLE=0, FETCH=1, COMPARE=2, ADVANCE=3, MISMATCH=4, VERIFY=5.
- One sub-module, fprint_ptr_pair, instantiated once per core. It holds the head and tail registers with wrap bit, inc/adv/flush inputs, and occ/full/empty outputs.
- A priority-encoder function for verified_task lives in the package.

Test Plan:
- Fill and compare: write 3 equal fingerprints per core (0xDEADBEEF, 0x12345678, 0x0). Expect 3 ADVANCE passes, tails = 3, match_count = 3, mismatch_irq stays 0.
- Mismatch: core0 gets 0xAAAA5555, core1 gets 0xAAAA5554, with 2 more entries queued behind. Expect mismatch_irq = 1 and mismatch_addr = 0. On irq_clear, expect tails = heads, occ = 0, irq = 0.
- Backpressure: with no compares running, issue 32 increments on core0. All are acked. The 33rd is held un-acked until core1 supplies a matching entry and ADVANCE frees a slot; it is then acked.
- Wrap: run 40 matched pairs through. Expect pointers to wrap 31→0, occ to stay correct, and match_count = 40.
- Verify: with both cores empty, set checkin = 0x0014. Expect task_verified with verified_task = 2; ack, then clear bit 2. Expect a second VERIFY with verified_task = 4.
- Reset mid-VERIFY: assert reset while task_verified = 1. Expect all outputs 0 on the same cycle (asynchronous) and the FSM in IDLE after release.
